conv_win_sched: RTL and testbench

- Sequencer for the 3x3 convolution adder stage. It tracks the row and column of a raster pixel stream and decides which cycles carry a complete 3x3 window.
- Drives the window-valid strobe into the 3x3 adder, and a result-valid/last strobe aligned to the adder's 2-cycle registered output.
- Sits between the line-buffer/window generator and the downstream pooling or accumulation stage. Frames are started on command and report completion.

---
 rtl/conv_win_sched_pkg.sv | 23 ++
 rtl/conv_win_sched_valid_delay_line.sv | 64 ++++++
 rtl/conv_win_sched.sv | 167 ++++++++++++++++
 tb/tb_conv_win_sched.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_win_sched_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
//   Shared types and constants for the 3x3 convolution window scheduler.
//   - state_t          : sequencer states (IDLE, RUN, FLUSH, DONE)
//   - KSIZE            : kernel edge length; a window is complete once
//                        KSIZE-1 previous rows and columns have been seen
//   - ADD_LAT_DEFAULT  : default pipeline latency of the 3x3 adder
//   - CW_DEFAULT       : default row/column counter width
// ---------------------------------------------------------------------------
package conv_pkg;

  localparam int KSIZE           = 3;
  localparam int ADD_LAT_DEFAULT = 2;
  localparam int CW_DEFAULT      = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/conv_win_sched_valid_delay_line.sv
// ---------------------------------------------------------------------------
// valid_delay_line
//   Fixed-depth shift register that carries the window tag
//   {valid, last, row, col} alongside the 3x3 adder, so the tag leaves the
//   line in the same cycle the matching sum leaves the adder. It shifts every
//   cycle regardless of input activity, so results are never stalled.
//
// Ports
//   sclk, s_rst_n      : clock, asynchronous active-low reset
//   in_valid, in_last  : window strobe / final-window flag entering the adder
//   in_row, in_col     : output coordinates of that window
//   out_*              : the same tag, DEPTH cycles later
// ---------------------------------------------------------------------------
module valid_delay_line #(
  parameter int DEPTH = 2,
  parameter int CW    = 10
) (
  input  logic          sclk,
  input  logic          s_rst_n,
  input  logic          in_valid,
  input  logic          in_last,
  input  logic [CW-1:0] in_row,
  input  logic [CW-1:0] in_col,
  output logic          out_valid,
  output logic          out_last,
  output logic [CW-1:0] out_row,
  output logic [CW-1:0] out_col
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] last_q;
  logic [CW-1:0]    row_q [DEPTH];
  logic [CW-1:0]    col_q [DEPTH];

  // NOTE: every stage is reset, including the coordinate array; a reset in
  // mid-frame must not leave stale strobes or indices draining out afterwards.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      valid_q <= '0;
      last_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        row_q[i] <= '0;
        col_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      last_q[0]  <= in_last;
      row_q[0]   <= in_row;
      col_q[0]   <= in_col;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        last_q[i]  <= last_q[i-1];
        row_q[i]   <= row_q[i-1];
        col_q[i]   <= col_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_last  = last_q[DEPTH-1];
  assign out_row   = row_q[DEPTH-1];
  assign out_col   = col_q[DEPTH-1];

endmodule

// File: rtl/conv_win_sched.sv
// ---------------------------------------------------------------------------
// conv_win_sched
//   Sequencer for the 3x3 convolution adder stage. Tracks the raster
//   position of the incoming pixel stream, flags the cycles on which a full
//   3x3 window is presented, and re-times that flag (plus the window's output
//   coordinates) to the adder's registered result.
//
// Ports
//   sclk, s_rst_n  : clock, asynchronous active-low reset
//   start          : one-cycle pulse, starts a frame when idle
//   pix_valid      : a pixel (and its window) is presented this cycle
//   win_valid      : adder input holds a complete window (combinational)
//   res_valid      : adder result valid this cycle
//   res_last       : with res_valid, final result of the frame
//   res_col/res_row: output coordinates of the current result
//   busy           : frame in progress (accepted start .. frame_done)
//   frame_done     : one-cycle pulse after the last result has drained
//   err_overrun    : sticky, pixel seen outside RUN; cleared by next start
// ---------------------------------------------------------------------------
module conv_win_sched
  import conv_pkg::*;
#(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int ADD_LAT = ADD_LAT_DEFAULT,
  parameter int CW      = CW_DEFAULT
) (
  input  logic          sclk,
  input  logic          s_rst_n,
  input  logic          start,
  input  logic          pix_valid,
  output logic          win_valid,
  output logic          res_valid,
  output logic          res_last,
  output logic [CW-1:0] res_col,
  output logic [CW-1:0] res_row,
  output logic          busy,
  output logic          frame_done,
  output logic          err_overrun
);

  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);
  localparam logic [CW-1:0] EDGE     = CW'(KSIZE - 1);

  // Flush counter must hold ADD_LAT-1; sized for ADD_LAT+1 so it is never 0 bits.
  localparam int             FW         = $clog2(ADD_LAT + 1);
  localparam logic [FW-1:0]  FLUSH_LAST = FW'(ADD_LAT - 1);

  state_t        state;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic [FW-1:0] flush_cnt;

  logic          win_last;
  logic [CW-1:0] win_row;
  logic [CW-1:0] win_col;

  // -------------------------------------------------------------------------
  // Window detection: evaluated on the counters before they advance, so the
  // pixel at (r,c) completes the window spanning rows r-2..r, cols c-2..c.
  // -------------------------------------------------------------------------
  assign win_valid = (state == ST_RUN) && pix_valid && (row >= EDGE) && (col >= EDGE);
  assign win_last  = win_valid && (row == LAST_ROW) && (col == LAST_COL);

  // Coordinates are zeroed for non-window cycles so the result indices read 0
  // whenever res_valid is low.
  assign win_row = win_valid ? (row - EDGE) : '0;
  assign win_col = win_valid ? (col - EDGE) : '0;

  // -------------------------------------------------------------------------
  // Sequencer with registered busy / frame_done / err_overrun.
  // -------------------------------------------------------------------------
  // NOTE: state and counters use non-blocking assignments so every branch
  // sees the pre-edge values, matching the combinational window test above.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state       <= ST_IDLE;
      row         <= '0;
      col         <= '0;
      flush_cnt   <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_RUN;
            row         <= '0;
            col         <= '0;
            busy        <= 1'b1;
            err_overrun <= 1'b0;
          end else if (pix_valid) begin
            err_overrun <= 1'b1;
          end
        end

        ST_RUN: begin
          // Bubbles (pix_valid low) simply hold the counters.
          if (pix_valid) begin
            if (col == LAST_COL) begin
              col <= '0;
              if (row == LAST_ROW) begin
                state     <= ST_FLUSH;
                flush_cnt <= '0;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end

        ST_FLUSH: begin
          if (pix_valid) begin
            err_overrun <= 1'b1;
          end
          // Final result leaves the adder on the last FLUSH cycle.
          if (flush_cnt == FLUSH_LAST) begin
            state      <= ST_DONE;
            frame_done <= 1'b1;
            busy       <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          // A start arriving here is dropped; the caller re-issues it.
          if (pix_valid) begin
            err_overrun <= 1'b1;
          end
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Result alignment: the window tag travels beside the adder pipeline.
  // -------------------------------------------------------------------------
  valid_delay_line #(
    .DEPTH (ADD_LAT),
    .CW    (CW)
  ) u_delay (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .in_valid  (win_valid),
    .in_last   (win_last),
    .in_row    (win_row),
    .in_col    (win_col),
    .out_valid (res_valid),
    .out_last  (res_last),
    .out_row   (res_row),
    .out_col   (res_col)
  );

endmodule

// File: tb/tb_conv_win_sched.sv
// ---------------------------------------------------------------------------
// tb_conv_win_sched
//   Self-checking bench for conv_win_sched. A 5x4 instance exercises the
//   cycle-exact behaviour (vector table plus directed sequences); a default
//   28x28 instance runs one full frame against a window-counting scoreboard.
//   Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_conv_win_sched;

  localparam int SW = 5;
  localparam int SH = 4;

  logic       sclk;
  logic       s_rst_n;

  // small instance
  logic       start, pix_valid;
  logic       win_valid, res_valid, res_last, busy, frame_done, err_overrun;
  logic [9:0] res_col, res_row;

  // default-size instance
  logic       b_start, b_pix_valid;
  logic       b_win_valid, b_res_valid, b_res_last, b_busy, b_frame_done, b_err_overrun;
  logic [9:0] b_res_col, b_res_row;

  int n_tests = 0;
  int n_fail  = 0;

  conv_win_sched #(.IMG_W(SW), .IMG_H(SH)) dut (
    .sclk        (sclk),
    .s_rst_n     (s_rst_n),
    .start       (start),
    .pix_valid   (pix_valid),
    .win_valid   (win_valid),
    .res_valid   (res_valid),
    .res_last    (res_last),
    .res_col     (res_col),
    .res_row     (res_row),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_overrun (err_overrun)
  );

  conv_win_sched dut_big (
    .sclk        (sclk),
    .s_rst_n     (s_rst_n),
    .start       (b_start),
    .pix_valid   (b_pix_valid),
    .win_valid   (b_win_valid),
    .res_valid   (b_res_valid),
    .res_last    (b_res_last),
    .res_col     (b_res_col),
    .res_row     (b_res_row),
    .busy        (b_busy),
    .frame_done  (b_frame_done),
    .err_overrun (b_err_overrun)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Vector table for the basic 5x4 frame, one entry per clock cycle.
  // ---------------------------------------------------------------------
  typedef struct {
    logic       st;
    logic       px;
    logic       win;
    logic       rv;
    logic       rl;
    logic [9:0] rr;
    logic [9:0] rc;
    logic       bsy;
    logic       fd;
    logic       err;
  } vec_t;

  vec_t tv [25];

  function automatic vec_t mk(input logic st, px, win, rv, rl, input int rr, rc,
                              input logic bsy, fd, err);
    vec_t v;
    v.st = st; v.px = px; v.win = win; v.rv = rv; v.rl = rl;
    v.rr = 10'(rr); v.rc = 10'(rc);
    v.bsy = bsy; v.fd = fd; v.err = err;
    return v;
  endfunction

  // ---------------------------------------------------------------------
  // 5x4 frame with optional bubbles and an optional stray start mid-frame.
  // Expected windows are derived from the bench's own pixel position.
  // ---------------------------------------------------------------------
  task automatic run_frame(input string tag, input int gap, input bit mid_start,
                           input bit err0);
    int  q_due[$];
    int  q_r[$];
    int  q_c[$];
    bit  q_l[$];
    int  k;
    int  nres;
    int  nlast;
    int  last_pix;
    bit  finished;
    bit  px;
    bit  exp_win;
    bit  exp_rv;
    bit  exp_rl;
    int  er, ec;
    k = 0; nres = 0; nlast = 0; last_pix = -1; finished = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (last_pix >= 0 && cyc > last_pix + 3) begin
        finished = 1;
        break;
      end
      px = (cyc >= 1) && (k < SW * SH) && (((cyc - 1) % (gap + 1)) == 0);
      @(negedge sclk);
      start     = (cyc == 0) || (mid_start && cyc == 8);
      pix_valid = px;
      exp_win   = px && (k / SW >= 2) && (k % SW >= 2);
      if (exp_win) begin
        q_due.push_back(cyc + 2);
        q_r.push_back(k / SW - 2);
        q_c.push_back(k % SW - 2);
        q_l.push_back(k == SW * SH - 1);
      end
      if (px) begin
        if (k == SW * SH - 1) last_pix = cyc;
        k++;
      end
      #1;
      check($sformatf("%s c%0d win_valid", tag, cyc), 32'(win_valid), 32'(exp_win));
      exp_rv = (q_due.size() > 0) && (q_due[0] == cyc);
      check($sformatf("%s c%0d res_valid", tag, cyc), 32'(res_valid), 32'(exp_rv));
      exp_rl = 1'b0;
      if (exp_rv) begin
        void'(q_due.pop_front());
        er = q_r.pop_front();
        ec = q_c.pop_front();
        exp_rl = q_l.pop_front();
        check($sformatf("%s c%0d res_row", tag, cyc), 32'(res_row), er);
        check($sformatf("%s c%0d res_col", tag, cyc), 32'(res_col), ec);
      end
      check($sformatf("%s c%0d res_last", tag, cyc), 32'(res_last), 32'(exp_rl));
      check($sformatf("%s c%0d frame_done", tag, cyc), 32'(frame_done),
            32'(last_pix >= 0 && cyc == last_pix + 3));
      check($sformatf("%s c%0d busy", tag, cyc), 32'(busy),
            32'(cyc >= 1 && (last_pix < 0 || cyc <= last_pix + 2)));
      check($sformatf("%s c%0d err_overrun", tag, cyc), 32'(err_overrun),
            32'(cyc == 0 ? err0 : 1'b0));
      if (res_valid) nres++;
      if (res_valid && res_last) nlast++;
    end
    start     = 1'b0;
    pix_valid = 1'b0;
    check({tag, " finished in budget"}, 32'(finished), 32'd1);
    check({tag, " result count"}, nres, 6);
    check({tag, " last count"}, nlast, 1);
    check({tag, " queue drained"}, q_due.size(), 0);
  endtask

  // ---------------------------------------------------------------------
  // Default 28x28 frame on the second instance, scoreboarded by window count.
  // ---------------------------------------------------------------------
  task automatic run_big();
    int q_due[$];
    int k, nwin, nres, nlast, last_pix, fd_cyc, last_res_cyc, bad_rv;
    bit px, exp_rv, finished;
    k = 0; nwin = 0; nres = 0; nlast = 0; last_pix = -1; fd_cyc = -1;
    last_res_cyc = -1; bad_rv = 0; finished = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (last_pix >= 0 && cyc > last_pix + 3) begin
        finished = 1;
        break;
      end
      px = (cyc >= 1) && (k < 28 * 28);
      @(negedge sclk);
      b_start     = (cyc == 0);
      b_pix_valid = px;
      if (px) begin
        if ((k / 28 >= 2) && (k % 28 >= 2)) begin
          nwin++;
          q_due.push_back(cyc + 2);
        end
        if (k == 28 * 28 - 1) last_pix = cyc;
        k++;
      end
      #1;
      exp_rv = (q_due.size() > 0) && (q_due[0] == cyc);
      if (exp_rv) void'(q_due.pop_front());
      if (b_res_valid !== exp_rv) bad_rv++;
      if (b_res_valid) begin
        nres++;
        last_res_cyc = cyc;
      end
      if (b_res_valid && b_res_last) nlast++;
      if (b_frame_done) fd_cyc = cyc;
    end
    b_start     = 1'b0;
    b_pix_valid = 1'b0;
    check("big finished in budget", 32'(finished), 32'd1);
    check("big scoreboard windows", nwin, 676);
    check("big res_valid count", nres, nwin);
    check("big res_valid timing errors", bad_rv, 0);
    check("big res_last count", nlast, 1);
    check("big last result cycle", last_res_cyc, last_pix + 2);
    check("big frame_done cycle", fd_cyc, last_pix + 3);
    check("big busy after frame", 32'(b_busy), 32'd0);
  endtask

  initial begin
    s_rst_n     = 1'b0;
    start       = 1'b0;
    pix_valid   = 1'b0;
    b_start     = 1'b0;
    b_pix_valid = 1'b0;

    // Basic frame: start at cycle 0, pixels k=0..19 at cycles 1..20.
    // Windows at k=12,13,14,17,18,19 -> results at cycles 15,16,17,20,21,22.
    tv[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 12; i++) tv[i] = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    tv[13] = mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    tv[14] = mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    tv[15] = mk(0, 1, 1, 1, 0, 0, 0, 1, 0, 0);
    tv[16] = mk(0, 1, 0, 1, 0, 0, 1, 1, 0, 0);
    tv[17] = mk(0, 1, 0, 1, 0, 0, 2, 1, 0, 0);
    tv[18] = mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    tv[19] = mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    tv[20] = mk(0, 1, 1, 1, 0, 1, 0, 1, 0, 0);
    tv[21] = mk(0, 0, 0, 1, 0, 1, 1, 1, 0, 0);
    tv[22] = mk(0, 0, 0, 1, 1, 1, 2, 1, 0, 0);
    tv[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tv[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    #12;
    check("reset win_valid", 32'(win_valid), 0);
    check("reset res_valid", 32'(res_valid), 0);
    check("reset res_last", 32'(res_last), 0);
    check("reset busy", 32'(busy), 0);
    check("reset frame_done", 32'(frame_done), 0);
    check("reset err_overrun", 32'(err_overrun), 0);
    check("reset res_row", 32'(res_row), 0);
    check("reset res_col", 32'(res_col), 0);
    @(negedge sclk);
    s_rst_n = 1'b1;

    // Table-driven basic frame
    for (int i = 0; i < 25; i++) begin
      @(negedge sclk);
      start     = tv[i].st;
      pix_valid = tv[i].px;
      #1;
      check($sformatf("vec%0d win_valid", i), 32'(win_valid), 32'(tv[i].win));
      check($sformatf("vec%0d res_valid", i), 32'(res_valid), 32'(tv[i].rv));
      check($sformatf("vec%0d res_last", i), 32'(res_last), 32'(tv[i].rl));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(tv[i].bsy));
      check($sformatf("vec%0d frame_done", i), 32'(frame_done), 32'(tv[i].fd));
      check($sformatf("vec%0d err_overrun", i), 32'(err_overrun), 32'(tv[i].err));
      if (tv[i].rv) begin
        check($sformatf("vec%0d res_row", i), 32'(res_row), 32'(tv[i].rr));
        check($sformatf("vec%0d res_col", i), 32'(res_col), 32'(tv[i].rc));
      end
    end
    start     = 1'b0;
    pix_valid = 1'b0;

    // Overrun while idle: no window, sticky error, cleared by the next start
    @(negedge sclk);
    pix_valid = 1'b1;
    #1;
    check("overrun win_valid", 32'(win_valid), 0);
    @(negedge sclk);
    pix_valid = 1'b0;
    #1;
    check("overrun err set", 32'(err_overrun), 1);
    @(negedge sclk);
    #1;
    check("overrun err sticky", 32'(err_overrun), 1);
    check("overrun stays idle", 32'(busy), 0);

    // Bubble frame (pixel every other cycle); its start clears the error
    run_frame("bubble", 1, 1'b0, 1'b1);

    // Stray start mid-frame is ignored
    run_frame("midstart", 0, 1'b1, 1'b0);

    // Reset after 15 pixels: everything drops at once, no frame_done
    @(negedge sclk);
    start = 1'b1;
    @(negedge sclk);
    start     = 1'b0;
    pix_valid = 1'b1;
    repeat (14) @(negedge sclk);
    #1;
    check("pre-reset busy", 32'(busy), 1);
    check("pre-reset win_valid", 32'(win_valid), 1);
    @(negedge sclk);
    s_rst_n = 1'b0;
    #1;
    check("midreset win_valid", 32'(win_valid), 0);
    check("midreset res_valid", 32'(res_valid), 0);
    check("midreset res_last", 32'(res_last), 0);
    check("midreset busy", 32'(busy), 0);
    check("midreset frame_done", 32'(frame_done), 0);
    check("midreset err_overrun", 32'(err_overrun), 0);
    check("midreset res_row", 32'(res_row), 0);
    check("midreset res_col", 32'(res_col), 0);
    pix_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sclk);
      #1;
      check($sformatf("reset hold%0d frame_done", i), 32'(frame_done), 0);
      check($sformatf("reset hold%0d res_valid", i), 32'(res_valid), 0);
    end
    s_rst_n = 1'b1;

    run_frame("postreset", 0, 1'b0, 1'b0);

    // Default-size frame
    run_big();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
